// File: rtl/imm_encoder.sv
// Streaming RISC-V immediate encoder: scatters an immediate into I/S/B/J/U positions of a base word.
// Optional round-trip self-check is compiled in with `define IMM_ENCODER_ROUNDTRIP_CHECK_EN.
module imm_encoder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_imm,
    input  logic [2:0]          in_immsrc,
    input  logic [31:0]         in_base,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_inst,
    output logic [31:0]         out_addr,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt,
    output logic                chk_fail
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [2:0] FmtI = 3'b000;
    localparam logic [2:0] FmtS = 3'b001;
    localparam logic [2:0] FmtJ = 3'b010;
    localparam logic [2:0] FmtB = 3'b101;
    localparam logic [2:0] FmtU = 3'b110;

    // Stage 1: registered inputs
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_imm_q, s1_imm_d;
    logic [2:0]  s1_src_q, s1_src_d;
    logic [31:0] s1_base_q, s1_base_d;

    // Stage 2: output register
    logic                s2_valid_q, s2_valid_d;
    logic [31:0]         s2_inst_q, s2_inst_d;
    logic                s2_err_q, s2_err_d;
    logic [AW-1:0]       ofs_q, ofs_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic        s2_load;
    logic        out_fire;
    logic [31:0] enc_inst;
    logic        enc_err;

    assign s2_load  = !s2_valid_q || out_ready;
    assign out_fire = s2_valid_q && out_ready;
    assign in_ready = rst_n && (!s1_valid_q || s2_load);

    always_comb begin
        enc_inst = s1_base_q;
        enc_err  = 1'b0;
        case (s1_src_q)
            FmtI: begin
                enc_inst[31:20] = s1_imm_q[11:0];
                enc_err         = s1_imm_q[31:11] != {21{s1_imm_q[11]}};
            end
            FmtS: begin
                enc_inst[31:25] = s1_imm_q[11:5];
                enc_inst[11:7]  = s1_imm_q[4:0];
                enc_err         = s1_imm_q[31:11] != {21{s1_imm_q[11]}};
            end
            FmtB: begin
                enc_inst[31]    = s1_imm_q[12];
                enc_inst[7]     = s1_imm_q[11];
                enc_inst[30:25] = s1_imm_q[10:5];
                enc_inst[11:8]  = s1_imm_q[4:1];
                enc_err         = (s1_imm_q[31:12] != {20{s1_imm_q[12]}}) || s1_imm_q[0];
            end
            FmtJ: begin
                enc_inst[31]    = s1_imm_q[20];
                enc_inst[19:12] = s1_imm_q[19:12];
                enc_inst[20]    = s1_imm_q[11];
                enc_inst[30:21] = s1_imm_q[10:1];
                enc_err         = (s1_imm_q[31:20] != {12{s1_imm_q[20]}}) || s1_imm_q[0];
            end
            FmtU: begin
                enc_inst[31:12] = s1_imm_q[19:0];
                enc_err         = s1_imm_q[31:19] != {13{s1_imm_q[19]}};
            end
            default: enc_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_src_d   = s1_src_q;
        s1_base_d  = s1_base_q;
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        ofs_d      = ofs_q;
        err_cnt_d  = err_cnt_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            s1_imm_d   = in_imm;
            s1_src_d   = in_immsrc;
            s1_base_d  = in_base;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            s2_inst_d  = enc_inst;
            s2_err_d   = enc_err;
        end
        if (out_fire) begin
            // Offset counter wraps naturally at DEPTH_WORDS (power of two)
            ofs_d = ofs_q + AW'(1);
            if (s2_err_q && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_src_q   <= '0;
            s1_base_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= '0;
            s2_err_q   <= 1'b0;
            ofs_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_src_q   <= s1_src_d;
            s1_base_q  <= s1_base_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
            ofs_q      <= ofs_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign out_addr  = BASE_ADDR + (32'(ofs_q) << 2);
    assign err_cnt   = err_cnt_q;

`ifdef IMM_ENCODER_ROUNDTRIP_CHECK_EN
    logic [31:0] s2_imm_q, s2_imm_d;
    logic [2:0]  s2_src_q, s2_src_d;
    logic        chk_fail_q, chk_fail_d;
    logic [31:0] dec_imm;

    // Independent decode of the emitted word, mirroring the immediate-extension unit
    always_comb begin
        case (s2_src_q)
            FmtI:    dec_imm = {{20{s2_inst_q[31]}}, s2_inst_q[31:20]};
            FmtS:    dec_imm = {{20{s2_inst_q[31]}}, s2_inst_q[31:25], s2_inst_q[11:7]};
            FmtB:    dec_imm = {{19{s2_inst_q[31]}}, s2_inst_q[31], s2_inst_q[7],
                                s2_inst_q[30:25], s2_inst_q[11:8], 1'b0};
            FmtJ:    dec_imm = {{11{s2_inst_q[31]}}, s2_inst_q[31], s2_inst_q[19:12],
                                s2_inst_q[20], s2_inst_q[30:21], 1'b0};
            FmtU:    dec_imm = {{12{s2_inst_q[31]}}, s2_inst_q[31:12]};
            default: dec_imm = '0;
        endcase
    end

    always_comb begin
        s2_imm_d   = s2_imm_q;
        s2_src_d   = s2_src_q;
        chk_fail_d = chk_fail_q;
        if (s2_load) begin
            s2_imm_d = s1_imm_q;
            s2_src_d = s1_src_q;
        end
        if (out_fire && !s2_err_q && (dec_imm != s2_imm_q)) begin
            chk_fail_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_imm_q   <= '0;
            s2_src_q   <= '0;
            chk_fail_q <= 1'b0;
        end else begin
            s2_imm_q   <= s2_imm_d;
            s2_src_q   <= s2_src_d;
            chk_fail_q <= chk_fail_d;
        end
    end

    assign chk_fail = chk_fail_q;
`else
    assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized scoreboard bench for imm_encoder against a bit-position/arithmetic reference model.
module tb_imm_encoder;

    localparam logic [31:0] Base  = 32'h0000_1000;
    localparam int unsigned Depth = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_imm = '0;
    logic [2:0]  in_immsrc = '0;
    logic [31:0] in_base = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;
    logic        chk_fail;

    imm_encoder #(
        .BASE_ADDR  (Base),
        .DEPTH_WORDS(Depth),
        .ERRCNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_immsrc(in_immsrc),
        .in_base  (in_base),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_inst (out_inst),
        .out_addr (out_addr),
        .out_err  (out_err),
        .err_cnt  (err_cnt),
        .chk_fail (chk_fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned exp_cnt = 0;
    int unsigned out_idx = 0;
    logic [31:0] last_inst = '0;
    logic [31:0] last_addr = '0;
    logic        last_err = 1'b0;
    bit          saw_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Destination bit of immediate bit k for a format, -1 when not encoded
    function automatic int dest_bit(input logic [2:0] src, input int k);
        case (src)
            3'b000: return (k <= 11) ? 20 + k : -1;
            3'b001: return (k <= 4) ? 7 + k : (k <= 11) ? 20 + k : -1;
            3'b101: begin
                if (k >= 1 && k <= 4) return 7 + k;
                if (k >= 5 && k <= 10) return 20 + k;
                if (k == 11) return 7;
                if (k == 12) return 31;
                return -1;
            end
            3'b010: begin
                if (k >= 1 && k <= 10) return 20 + k;
                if (k == 11) return 20;
                if (k >= 12 && k <= 19) return k;
                if (k == 20) return 31;
                return -1;
            end
            3'b110: return (k <= 19) ? 12 + k : -1;
            default: return -1;
        endcase
    endfunction

    function automatic int fmt_bits(input logic [2:0] src);
        case (src)
            3'b000, 3'b001: return 12;
            3'b101:         return 13;
            3'b010:         return 21;
            3'b110:         return 20;
            default:        return 0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] imm, input logic [2:0] src,
                                   input logic [31:0] base);
        exp_t   e;
        int     n;
        int     p;
        longint v;
        longint lim;
        n      = fmt_bits(src);
        e.inst = base;
        e.err  = 1'b1;
        if (n != 0) begin
            v     = longint'($signed(imm));
            lim   = longint'(1) << (n - 1);
            e.err = (v < -lim) || (v >= lim) || ((src == 3'b101 || src == 3'b010) && imm[0]);
            for (int k = 0; k < 21; k++) begin
                p = dest_bit(src, k);
                if (p >= 0) e.inst[p] = imm[k];
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_legal(input logic [2:0] src);
        logic signed [31:0] s;
        int                 n;
        n = fmt_bits(src);
        s = $signed($urandom);
        if (n != 0) s = s >>> (32 - n);
        if (src == 3'b101 || src == 3'b010) s[0] = 1'b0;
        return s;
    endfunction

    // One clock: drive at negedge, sample 1ns later, score transfers of the coming edge
    task automatic cycle(input logic v, input logic [31:0] imm, input logic [2:0] src,
                         input logic [31:0] base, input logic rdy, output bit took);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_imm    = imm;
        in_immsrc = src;
        in_base   = base;
        out_ready = rdy;
        #1;
        check("err_cnt", 32'(err_cnt), exp_cnt);
        check("chk_fail", 32'(chk_fail), 32'd0);
        took = v && in_ready;
        if (!in_ready) saw_stall = 1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_inst", out_inst, e.inst);
                check("out_err", 32'(out_err), 32'(e.err));
                check("out_addr", out_addr, Base + 32'(4 * (out_idx % Depth)));
                out_idx++;
                if (e.err && exp_cnt < 255) exp_cnt++;
            end
            last_inst = out_inst;
            last_err  = out_err;
            last_addr = out_addr;
        end
        if (took) exp_q.push_back(model(imm, src, base));
    endtask

    task automatic send(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base,
                        input logic rdy);
        bit took;
        int guard;
        took  = 0;
        guard = 0;
        while (!took && guard < 50) begin
            cycle(1'b1, imm, src, base, rdy, took);
            guard++;
        end
        if (!took) check("send_timeout", 32'(took), 32'd1);
    endtask

    task automatic drain();
        bit took;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, '0, 1'b1, took);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        cycle(1'b0, '0, '0, '0, 1'b1, took);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_addr", out_addr, Base);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_chk_fail", 32'(chk_fail), 32'd0);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);
        exp_q.delete();
        exp_cnt = 0;
        out_idx = 0;
    endtask

    initial begin
        bit          took;
        logic [2:0]  src;
        logic [2:0]  legal_src[5] = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b110};
        logic [31:0] imm;

        do_reset();

        send(32'hFFFF_F800, 3'b000, 32'h0000_0013, 1'b1);
        drain();
        check("i_min_inst", last_inst, 32'h8000_0013);
        check("i_min_err", 32'(last_err), 32'd0);
        check("i_min_addr", last_addr, Base);

        send(32'h0000_0FFE, 3'b101, 32'h0000_0063, 1'b1);
        drain();
        check("b_max_inst", last_inst, 32'h7E00_0FE3);
        check("b_max_err", 32'(last_err), 32'd0);
        send(32'h0000_0FFF, 3'b101, 32'h0000_0063, 1'b1);
        drain();
        check("b_odd_err", 32'(last_err), 32'd1);
        check("b_odd_cnt", 32'(err_cnt), 32'd1);

        send(32'h0008_0000, 3'b110, 32'h0000_0037, 1'b1);
        drain();
        check("u_ovf_err", 32'(last_err), 32'd1);
        send(32'hFFF0_0000, 3'b010, 32'h0000_006F, 1'b1);
        drain();
        check("j_neg_inst", last_inst, 32'h8000_006F);
        check("j_neg_err", 32'(last_err), 32'd0);
        send(32'h0000_0005, 3'b111, 32'h1234_5677, 1'b1);
        drain();
        check("illegal_inst", last_inst, 32'h1234_5677);
        check("illegal_err", 32'(last_err), 32'd1);

        // Six-beat stream with out_ready low on cycles 3..5
        do_reset();
        saw_stall = 0;
        begin
            int c;
            int sent;
            c    = 0;
            sent = 0;
            while (sent < 6 && c < 60) begin
                cycle(1'b1, 32'(sent * 4), 3'b000, 32'h0000_0013, !(c >= 3 && c <= 5), took);
                if (took) sent++;
                c++;
            end
            check("stream_sent", 32'(sent), 32'd6);
        end
        drain();
        check("stream_stall", 32'(saw_stall), 32'd1);
        check("stream_last_addr", last_addr, Base + 32'd20);
        for (int i = 0; i < 3; i++) send(32'(i), 3'b000, 32'h0000_0013, 1'b1);
        drain();
        check("wrap_addr", last_addr, Base);

        // Fill both stages, then reset
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i), 3'b001, 32'h0000_0023, 1'b0, took);
        check("full_before_rst", 32'(out_valid), 32'd1);
        do_reset();

        for (int i = 0; i < 800; i++) begin
            src = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                              : legal_src[$urandom_range(0, 4)];
            imm = ($urandom_range(0, 3) == 0) ? $urandom : rand_legal(src);
            cycle($urandom_range(0, 3) != 0, imm, src, $urandom, $urandom_range(0, 3) != 0, took);
        end
        drain();

        do_reset();
        for (int i = 0; i < 300; i++) send($urandom, 3'b011 + 3'($urandom_range(0, 1)), $urandom, 1'b1);
        drain();
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming immediate encoder: the inverse of the immediate-extension unit.
- Accepts a 32-bit immediate value, an Immsrc format code and a base instruction word that carries the non-immediate fields (opcode, rd, rs1, rs2, funct3, funct7).
- Scatters the immediate bits into the RISC-V I/S/B/J/U bit positions, range-checks the value and emits the instruction word with a write address.
- Sits between the test/boot program generator and instruction-memory write port.
- Two-stage valid/ready pipeline.

Parameters:
- BASE_ADDR, 32'h0000_0000, first output address after reset.
- DEPTH_WORDS, 256, instruction-memory depth in words; out_addr wraps after DEPTH_WORDS beats (power of 2, >=2).
- ERRCNT_W, 8, width of saturating error counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  encoder can accept beat
- in_imm  in  32  immediate value (signed, unshifted, in the same form the decoder produces)
- in_immsrc  in  3  format: 000 I, 001 S, 101 B, 010 J, 110 U
- in_base  in  32  instruction word; immediate bit positions ignored
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_inst  out  32  encoded instruction
- out_addr  out  32  byte address for out_inst
- out_err  out  1  beat's immediate out of range or format illegal
- err_cnt  out  ERRCNT_W  saturating count of accepted error beats
- chk_fail  out  1  round-trip mismatch (see Optional Feature)

Behaviour:
- Reset (rst_n low at a clk edge):
  - Both stages are emptied; in-flight beats are dropped.
  - in_ready=0 during reset, 1 on the first cycle after.
  - out_valid=0, out_inst=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0, chk_fail=0.
- Handshake:
  - Transfer occurs when valid&&ready on a clk edge.
  - Once out_valid=1, out_inst, out_addr and out_err stay stable until accepted.
  - in_ready depends on out_ready combinationally only through the pipeline-advance term; there is no path from in_valid to in_ready.
- Pipeline:
  - S1 registers inputs and computes the encoding and range check. S2 is the output register.
  - Latency: accept at edge N gives out_valid at edge N+2 when there are no stalls.
  - Throughput: 1 beat/cycle while out_ready=1.
  - S2 loads when it is empty or being accepted. S1 advances under the same condition.
  - in_ready = !s1_valid || s2_load.
  - Back-pressure holds both stages; no beat is lost or duplicated.
- Encoding: out_inst starts from in_base, then bits are overwritten per format:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]
  - U: [31:12]=imm[19:0]
- Range rules (out_err=1 on violation; bits are still packed from the truncated value):
  - I/S: imm must equal the sign-extension of imm[11:0].
  - B: imm must equal the sign-extension of imm[12:0], and imm[0]=0.
  - J: imm must equal the sign-extension of imm[20:0], and imm[0]=0.
  - U: imm must equal the sign-extension of imm[19:0].
  - Illegal immsrc (011, 100, 111): out_inst=in_base unchanged, out_err=1.
- Address:
  - Advances by 4 on each output transfer.
  - After DEPTH_WORDS transfers it returns to BASE_ADDR, i.e. it wraps modulo DEPTH_WORDS*4 relative to BASE_ADDR.
- err_cnt:
  - Increments on each output transfer with out_err=1.
  - Saturates at all-ones and does not wrap.

Optional Feature:
- Macro IMM_ENCODER_ROUNDTRIP_CHECK_EN.
- Defined:
  - S2 decodes out_inst back through the Immsrc extension rules and compares the result with the registered imm.
  - chk_fail is set sticky (cleared only by reset) when a transferred beat with out_err=0 mismatches.
- Undefined: chk_fail tied to 0; no decode logic is present.

Test Plan:
- Reset, then I-format imm=32'hFFFF_F800 with base=32'h0000_0013 and out_ready=1 -> 2 cycles later out_inst=32'h8000_0013, out_err=0, out_addr=BASE_ADDR.
- B-format imm=32'h0000_0FFE, base=32'h0000_0063 -> out_inst=32'h7E00_0FE3, out_err=0. Same with imm=32'h0000_0FFF -> out_err=1 and err_cnt=1.
- U imm=32'h0008_0000 (exceeds 20-bit signed) -> out_err=1. J imm=32'hFFF0_0000 -> out_inst[31]=1, [19:12]=8'h00, out_err=0.
- Stream of 6 beats with out_ready low for cycles 3-5 -> in_ready drops, all 6 outputs arrive in order, no duplicates, out_addr = BASE_ADDR+0 through +20.
- DEPTH_WORDS=4 with 5 transfers -> 5th out_addr=BASE_ADDR. Illegal immsrc=3'b111 -> out_inst=base and out_err=1. 300 error beats with ERRCNT_W=8 -> err_cnt=255.
- rst_n low for one cycle while both stages are full -> next cycle out_valid=0 and out_addr=BASE_ADDR. With IMM_ENCODER_ROUNDTRIP_CHECK_EN, randomized legal beats -> chk_fail stays 0.
